tron_plot_arbiter: RTL
======================

# tron_plot_arbiter

Shares the single `vga_adapter` write port between the two tron datapaths and sequences full-screen clears. After reset, and on request, it sweeps all 160x120 pixels to a background colour. Otherwise it grants one plot request per two cycles between player A and player B using round-robin arbitration. It sits between `tron_datapath_1`/`tron_datapath_2` and the VGA adapter's `x`/`y`/`colour`/`plot` inputs.

## Interface
Parameters:
- `X_MAX`, default 159: last valid column.
- `Y_MAX`, default 119: last valid row.
- `CLEAR_COLOUR`, default 3'b000: colour written during a clear sweep.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `clear_req` in 1: one-cycle pulse requesting a screen clear. Sticky until serviced.
- `req_a` in 1: player A plot request. Held until `ack_a`.
- `x_a` in 8, `y_a` in 7, `colour_a` in 3: player A pixel. Stable while `req_a` is high.
- `ack_a` out 1: one-cycle grant/completion pulse for A.
- `req_b`, `x_b`, `y_b`, `colour_b`, `ack_b`: same as A, for player B.
- `x` out 8, `y` out 7, `colour` out 3: registered pixel to the VGA adapter.
- `plot` out 1: registered write enable to the VGA adapter.
- `busy` out 1: high while clearing.
- `oor` out 1: one-cycle pulse when a granted request is out of range and dropped.

## Operation
- All outputs are registered.
- **Reset values:** `x`=0, `y`=0, `colour`=0, `plot`=0, `ack_a`=`ack_b`=0, `oor`=0, `busy`=1.
- **Reset state:** state=CLEAR, clear counters cx=cy=0, priority pointer=A, clear_pending=0.
- **States:**
  - CLEAR:
    - Each cycle: `plot`=1, (`x`,`y`)=(cx,cy), `colour`=`CLEAR_COLOUR`.
    - cx increments 0..`X_MAX`. At wrap, cx=0 and cy increments.
    - After emitting (`X_MAX`,`Y_MAX`), go to IDLE.
    - No acks are issued in CLEAR; requests wait.
  - IDLE:
    - `plot`=0, `busy`=0.
    - Priority: clear_pending beats plot requests.
    - If clear_pending: clear it, reset cx=cy=0, go to CLEAR.
    - Else if any request: select a winner, latch its `x`/`y`/`colour`, go to PLOT.
  - PLOT (exactly one cycle):
    - `ack_winner`=1, and `plot`=1 with the latched pixel.
    - If the latched x>`X_MAX` or y>`Y_MAX`: `plot`=0 and `oor`=1; the ack is still issued.
    - Always return to IDLE.
- **Arbitration (round robin):**
  - Both requesting: the pointer holder wins.
  - One requesting: it wins.
  - After a grant, the pointer moves to the non-winner.
- **Handshake:**
  - Requester drops `req` on the edge where it samples `ack`=1.
  - `req` still high in the following IDLE cycle counts as a new request.
- **clear_req:**
  - Latched into clear_pending in any state.
  - A pulse during CLEAR sets clear_pending, so a second full sweep follows the current one.
- **Arithmetic:**
  - cx is 8-bit and cy is 7-bit.
  - Comparisons use exact equality to `X_MAX`/`Y_MAX`; no overflow past them.

## Timing
- **First clear pixel:** (0,0) with `plot`=1 in the first cycle after `reset` deasserts.
- **Clear duration:** (X_MAX+1)*(Y_MAX+1) = 19200 consecutive `plot` cycles.
- **Leaving CLEAR:** `busy` falls in the cycle after pixel (159,119).
- **Plot latency:** request sampled in IDLE at edge N gives `plot`/`ack` high during cycle N+1. Sampled data is the values present at edge N.
- **Throughput:** maximum one grant per 2 cycles. Requests sampled during PLOT or CLEAR are ignored until IDLE.
- **Simultaneous events:**
  - `clear_req` together with both `req`s in IDLE: the clear wins. Both requests are serviced after the sweep.
- **Reset mid-operation:**
  - Any state, including mid-sweep or mid-PLOT, returns to the reset values.
  - Pending requests are not acked.
  - The sweep restarts at (0,0).
  - The pointer returns to A.

## Test plan
- **Reset sweep:** release `reset` -> `plot`=1 for 19200 cycles; first pixel (0,0); pixel 160 is (0,1); last pixel (159,119) with colour 000; `busy`=0 on cycle 19201; no acks during the sweep.
- **Round robin:** after the sweep, hold `req_a` (25,25,001) and `req_b` (100,100,100) -> A plots first and gets `ack_a`; B plots 2 cycles later and gets `ack_b`. Re-raise both -> B is not first again; A wins (pointer alternation verified over 4 grants).
- **Out of range:** `req_a` with x=160, y=10 -> `ack_a`=1, `oor`=1, `plot`=0. Same for y=120.
- **Clear priority:** `clear_req` pulse together with `req_b` in IDLE -> full 19200-cycle sweep, then `ack_b` with B's pixel.
- **Reset mid-sweep:** assert `reset` at sweep pixel (50,40) -> next cycle `plot`=0, `busy`=1; after release the sweep restarts at (0,0).
- **Held request:** keep `req_a` high after `ack_a` -> a second grant occurs 2 cycles after the first ack, with the new data.

Source files
------------

// File: rtl/tron_plot_arbiter.sv
// tron_plot_arbiter: shares the VGA adapter write port between the two tron
// datapaths and sequences full-screen clear sweeps. All outputs are registered.
module tron_plot_arbiter #(
    parameter int         X_MAX        = 159,
    parameter int         Y_MAX        = 119,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_req,
    input  logic       req_a,
    input  logic [7:0] x_a,
    input  logic [6:0] y_a,
    input  logic [2:0] colour_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [7:0] x_b,
    input  logic [6:0] y_b,
    input  logic [2:0] colour_b,
    output logic       ack_b,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       oor
);

    localparam logic [7:0] XM = X_MAX[7:0];
    localparam logic [6:0] YM = Y_MAX[6:0];

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_PLOT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic       ptr_b_q, ptr_b_d;      // 1: player B holds priority
    logic       pend_q, pend_d;        // sticky clear request
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       ack_a_q, ack_a_d;
    logic       ack_b_q, ack_b_d;
    logic       oor_q, oor_d;
    logic       busy_q, busy_d;

    logic       grant_a;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_c;
    logic       in_range;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_CLEAR;
            cx_q     <= '0;
            cy_q     <= '0;
            ptr_b_q  <= 1'b0;
            pend_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            oor_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            ptr_b_q  <= ptr_b_d;
            pend_q   <= pend_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            oor_q    <= oor_d;
            busy_q   <= busy_d;
        end
    end

    // Next state plus the output values presented in the following cycle.
    // A grant decided in IDLE is written straight into the output registers,
    // so the PLOT state is the cycle in which plot/ack are visible.
    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        ptr_b_d  = ptr_b_q;
        pend_d   = pend_q | clear_req;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        oor_d    = 1'b0;
        busy_d   = 1'b0;

        grant_a  = req_a && (!req_b || !ptr_b_q);
        sel_x    = grant_a ? x_a : x_b;
        sel_y    = grant_a ? y_a : y_b;
        sel_c    = grant_a ? colour_a : colour_b;
        in_range = (sel_x <= XM) && (sel_y <= YM);

        case (state_q)
            S_CLEAR: begin
                plot_d   = 1'b1;
                busy_d   = 1'b1;
                x_d      = cx_q;
                y_d      = cy_q;
                colour_d = CLEAR_COLOUR;
                if (cx_q == XM) begin
                    cx_d = '0;
                    if (cy_q == YM) begin
                        cy_d    = '0;
                        state_d = S_IDLE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            S_IDLE: begin
                if (pend_q || clear_req) begin
                    pend_d  = 1'b0;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = S_CLEAR;
                end else if (req_a || req_b) begin
                    x_d      = sel_x;
                    y_d      = sel_y;
                    colour_d = sel_c;
                    plot_d   = in_range;
                    oor_d    = !in_range;
                    ack_a_d  = grant_a;
                    ack_b_d  = !grant_a;
                    ptr_b_d  = grant_a;
                    state_d  = S_PLOT;
                end
            end
            S_PLOT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign ack_a  = ack_a_q;
    assign ack_b  = ack_b_q;
    assign oor    = oor_q;
    assign busy   = busy_q;

endmodule
